// File: rtl/argmax_seq_ctrl.sv
// -----------------------------------------------------------------------------
// argmax_seq_ctrl
//
// Serial argmax over one classification frame. A frame is opened with start,
// then HEIGHT signed Q(BITS_INT.BITS_FRC) scores arrive one per beat over a
// valid/ready handshake. The running signed maximum and its index are tracked;
// when the frame closes the predicted class is presented over a second
// valid/ready handshake. Framing problems (early or missing in_last) are
// reported through frame_err, with predict_num forced to NO_CLASS.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start        single-cycle request to open a frame
//   abort        synchronous abandon of the current frame (highest priority)
//   in_valid     score beat valid
//   in_data      score, two's complement Q(BITS_INT.BITS_FRC)
//   in_last      final beat marker
//   in_ready     beat accepted when high (decoded from state only)
//   out_valid    result valid, held until out_ready
//   out_ready    consumer takes the result
//   predict_num  winning index 0..HEIGHT-1 (zero-extended) or NO_CLASS
//   max_score    winning score
//   frame_err    framing error flag, meaningful while out_valid=1
//   busy         high whenever the controller is not idle (decoded from state)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module argmax_seq_ctrl #(
  parameter int BITS_INT = 4,
  parameter int BITS_FRC = 12,
  parameter int HEIGHT   = 10,
  parameter int NO_CLASS = 15,
  localparam int W       = BITS_INT + BITS_FRC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] predict_num,
  output logic [W-1:0] max_score,
  output logic         frame_err,
  output logic         busy
);

  localparam int            IW            = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [IW-1:0] LAST_IDX      = IW'(HEIGHT - 1);
  localparam logic [W-1:0]  NO_CLASS_CODE = W'(NO_CLASS);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;       // position of the next beat within the frame
  logic [IW-1:0] best_idx;  // index of the running maximum

  logic          at_last_idx;
  logic          take;
  logic          end_beat;
  logic          beat_err;
  logic [IW-1:0] win_idx;

  // Handshake-side outputs decode from state alone, so no input reaches them
  // combinationally.
  assign in_ready = (state == COLLECT);
  assign busy     = (state != IDLE);

  always_comb begin
    at_last_idx = (idx == LAST_IDX);
    // First beat seeds the maximum unconditionally; afterwards strictly
    // greater wins, so ties keep the lowest index.
    take        = (idx == '0) || ($signed(in_data) > $signed(max_score));
    // The frame closes on an explicit in_last or on the HEIGHT-th beat,
    // whichever comes first; any disagreement between the two is an error.
    end_beat    = in_last || at_last_idx;
    beat_err    = (in_last && !at_last_idx) || (!in_last && at_last_idx);
    win_idx     = take ? idx : best_idx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      best_idx    <= '0;
      out_valid   <= 1'b0;
      predict_num <= NO_CLASS_CODE;
      max_score   <= '0;
      frame_err   <= 1'b0;
    end else if (abort) begin
      state       <= IDLE;
      idx         <= '0;
      out_valid   <= 1'b0;
      predict_num <= NO_CLASS_CODE;
      frame_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= COLLECT;
            idx       <= '0;
            frame_err <= 1'b0;
          end
        end

        COLLECT: begin
          if (in_valid) begin
            if (take) begin
              max_score <= in_data;
              best_idx  <= idx;
            end
            if (end_beat) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              frame_err   <= beat_err;
              predict_num <= beat_err ? NO_CLASS_CODE : W'(win_idx);
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            idx       <= '0;
            // A start coinciding with the result handshake opens the next
            // frame without passing through IDLE.
            if (start) begin
              state     <= COLLECT;
              frame_err <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_seq_ctrl.sv
`timescale 1ns/1ps

module tb_argmax_seq_ctrl;

  localparam int BITS_INT = 4;
  localparam int BITS_FRC = 12;
  localparam int W        = BITS_INT + BITS_FRC;
  localparam int HEIGHT   = 10;
  localparam int NO_CLASS = 15;

  typedef logic [W-1:0] score_t;
  typedef struct {
    score_t pred;
    score_t mx;
    logic   err;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset = 1'b0;
  logic   start = 1'b0;
  logic   abort = 1'b0;
  logic   in_valid = 1'b0;
  logic   in_last = 1'b0;
  logic   out_ready = 1'b0;
  score_t in_data = '0;
  logic   in_ready, out_valid, frame_err, busy;
  score_t predict_num, max_score;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  exp_t        sb[$];

  argmax_seq_ctrl #(
    .BITS_INT(BITS_INT),
    .BITS_FRC(BITS_FRC),
    .HEIGHT  (HEIGHT),
    .NO_CLASS(NO_CLASS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .predict_num(predict_num),
    .max_score  (max_score),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: scan the accepted beats, keep the first strictly-greater max.
  function automatic exp_t model(input score_t sc[HEIGHT], input int last_pos);
    int   end_pos;
    int   best;
    exp_t e;
    end_pos = (last_pos >= 0 && last_pos < HEIGHT) ? last_pos : HEIGHT - 1;
    best = 0;
    for (int i = 1; i <= end_pos; i++)
      if ($signed(sc[i]) > $signed(sc[best])) best = i;
    e.err  = (last_pos != HEIGHT - 1);
    e.mx   = sc[best];
    e.pred = e.err ? score_t'(NO_CLASS) : score_t'(best);
    return e;
  endfunction

  // Drives one frame's beats (controller already collecting); returns #1
  // after the edge that accepted the ending beat.
  task automatic send_frame(input score_t sc[HEIGHT], input int last_pos, input int gap_pct);
    sb.push_back(model(sc, last_pos));
    for (int i = 0; i < HEIGHT; i++) begin
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = score_t'($urandom);
        tick();
      end
      in_valid = 1'b1;
      in_data  = sc[i];
      in_last  = (i == last_pos);
      tick();
      if (i == last_pos || i == HEIGHT - 1) break;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic start_pulse;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Monitor: pops on every result handshake, and checks that a stalled
  // result does not move while waiting for out_ready.
  initial begin
    logic   held;
    exp_t   snap;
    exp_t   e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset || !out_valid) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("stall_pred", predict_num, snap.pred);
          check("stall_max", max_score, snap.mx);
          check("stall_err", W'(frame_err), W'(snap.err));
        end
        if (out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: got pred=%h max=%h with no frame outstanding", predict_num, max_score);
          end else begin
            e = sb.pop_front();
            check("result_pred", predict_num, e.pred);
            check("result_max", max_score, e.mx);
            check("result_err", W'(frame_err), W'(e.err));
          end
          held = 1'b0;
        end else begin
          held      = 1'b1;
          snap.pred = predict_num;
          snap.mx   = max_score;
          snap.err  = frame_err;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    score_t      basic[HEIGHT];
    score_t      sc[HEIGHT];
    int unsigned c0;
    int          lp;
    int          r;

    for (int i = 0; i < HEIGHT - 1; i++) basic[i] = score_t'((i + 1) * 16'h0100);
    basic[HEIGHT-1] = 16'h0050;

    // Reset values
    #12;
    check("rst_in_ready", W'(in_ready), '0);
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_busy", W'(busy), '0);
    check("rst_pred", predict_num, score_t'(NO_CLASS));
    check("rst_max", max_score, '0);
    check("rst_err", W'(frame_err), '0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Basic frame with latency
    out_ready = 1'b1;
    start_pulse();
    c0 = cyc;
    check("start_in_ready", W'(in_ready), W'(1));
    check("start_busy", W'(busy), W'(1));
    send_frame(basic, HEIGHT - 1, 0);
    check("latency", W'(cyc - c0), W'(HEIGHT));
    check("basic_out_valid", W'(out_valid), W'(1));
    tick();
    check("after_hs_out_valid", W'(out_valid), '0);
    check("after_hs_busy", W'(busy), '0);

    // All negative, equal scores
    for (int i = 0; i < HEIGHT; i++) sc[i] = 16'hF000;
    start_pulse();
    send_frame(sc, HEIGHT - 1, 0);
    tick();

    // Tie at 3 and 7
    for (int i = 0; i < HEIGHT; i++) sc[i] = score_t'(i * 16'h0100);
    sc[3] = 16'h3000;
    sc[7] = 16'h3000;
    start_pulse();
    send_frame(sc, HEIGHT - 1, 0);
    tick();

    // Early in_last on beat 5 (a larger later score must not count)
    for (int i = 0; i < HEIGHT; i++) sc[i] = score_t'(i * 16'h0110);
    sc[7] = 16'h7000;
    start_pulse();
    send_frame(sc, 5, 0);
    tick();

    // Ten beats without in_last
    start_pulse();
    send_frame(basic, -1, 0);
    tick();

    // Input gaps plus output stalled 7 cycles
    out_ready = 1'b0;
    start_pulse();
    send_frame(basic, HEIGHT - 1, 40);
    for (int k = 0; k < 7; k++) begin
      check("stall_out_valid", W'(out_valid), W'(1));
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("stall_released", W'(out_valid), '0);

    // Abort after beat 4, with a beat offered in the abort cycle
    start_pulse();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = basic[i];
      tick();
    end
    abort   = 1'b1;
    in_data = 16'h7FFF;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_out_valid", W'(out_valid), '0);
    check("abort_pred", predict_num, score_t'(NO_CLASS));
    check("abort_busy", W'(busy), '0);
    check("abort_in_ready", W'(in_ready), '0);
    repeat (12) tick();
    check("abort_no_result", W'(out_valid), '0);

    // Asynchronous reset mid-frame
    start_pulse();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = basic[i];
      tick();
    end
    in_valid = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check("arst_out_valid", W'(out_valid), '0);
    check("arst_in_ready", W'(in_ready), '0);
    check("arst_busy", W'(busy), '0);
    check("arst_pred", predict_num, score_t'(NO_CLASS));
    check("arst_max", max_score, '0);
    check("arst_err", W'(frame_err), '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
    for (int i = 0; i < HEIGHT; i++) sc[i] = score_t'($urandom);
    start_pulse();
    send_frame(sc, HEIGHT - 1, 0);
    tick();

    // Back-to-back frames
    start_pulse();
    send_frame(basic, HEIGHT - 1, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_in_ready", W'(in_ready), W'(1));
    for (int i = 0; i < HEIGHT; i++) sc[i] = score_t'(16'h8000 + i * 16'h0300);
    send_frame(sc, HEIGHT - 1, 0);
    tick();

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < HEIGHT; i++)
        sc[i] = (f % 2 == 0) ? score_t'($urandom) : score_t'($urandom_range(15) << 12);
      r = int'($urandom_range(9));
      lp = (r < 6) ? HEIGHT - 1 : (r < 8) ? int'($urandom_range(HEIGHT - 2)) : -1;
      out_ready = $urandom_range(1) == 1;
      start_pulse();
      send_frame(sc, lp, int'($urandom_range(50)));
      repeat ($urandom_range(3)) tick();
      out_ready = 1'b1;
      tick();
    end

    repeat (5) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_results: got %0d outstanding expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
